// File: rtl/seq_divider.sv
// Multicycle signed divider. A restoring divider runs on operand magnitudes, one quotient bit per
// cycle, and signs are applied at the end: the quotient truncates toward zero and the remainder
// takes the sign of the dividend. A zero divisor completes at once with a div_zero pulse and
// leaves the previous results in place.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e           state;
  logic [WIDTH-1:0] qmag;
  logic [WIDTH-1:0] dmag;
  logic [WIDTH-1:0] prem;
  logic [CntW-1:0]  cnt;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;

  // Operand magnitudes and the combinational part of one restoring step.
  always_comb begin
    dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
    divisor_abs  = divisor[WIDTH-1] ? -divisor : divisor;
    // Shifted value is the full WIDTH+1-bit partial remainder; the stored one never needs the
    // extra bit because a kept remainder is always below the divisor magnitude.
    shifted      = {prem, qmag[WIDTH-1]};
    trial        = shifted - {1'b0, dmag};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      qmag      <= '0;
      dmag      <= '0;
      prem      <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            if (divisor == '0) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              qmag   <= dividend_abs;
              dmag   <= divisor_abs;
              prem   <= '0;
              cnt    <= '0;
              sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sign_r <= dividend[WIDTH-1];
              busy   <= 1'b1;
              state  <= StRun;
            end
          end
        end
        StRun: begin
          if (!trial[WIDTH]) begin
            prem <= trial[WIDTH-1:0];
            qmag <= {qmag[WIDTH-2:0], 1'b1};
          end else begin
            prem <= shifted[WIDTH-1:0];
            qmag <= {qmag[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CntW'(WIDTH - 1)) begin
            state <= StFinish;
          end
        end
        StFinish: begin
          quotient  <= sign_q ? -qmag : qmag;
          remainder <= sign_r ? -prem : prem;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= StIdle;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus randomized operands compared
// against plain signed arithmetic.
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int tests_run;
  int tests_failed;

  // Last non-zero-divisor result, which the outputs must hold.
  logic [31:0] exp_q;
  logic [31:0] exp_r;

  seq_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .quotient (quotient),
    .remainder(remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating signed division on 64-bit integers, result taken mod 2^32.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    q  = 32'(sa / sb);
    r  = 32'(sa % sb);
  endfunction

  // Issue one request and wait (bounded) for done; reports edges from the start edge to done.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output int lat, output int busy_cnt);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #12;
    tests_run++;
    if ({busy, done, div_zero, quotient, remainder} !== 67'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b q=%h r=%h, want all zero",
               busy, done, div_zero, quotient, remainder);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, div_zero, quotient, remainder} !== 67'd0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got busy=%b done=%b dz=%b q=%h r=%h, want all zero",
               busy, done, div_zero, quotient, remainder);
    end
    exp_q = '0;
    exp_r = '0;
  endtask

  task automatic test_basic;
    logic [31:0] q, r;
    logic dz;
    int lat, bc;
    run_div(32'd100, 32'd7, q, r, dz, lat, bc);
    tests_run++;
    if (lat !== 33 || bc !== 33) begin
      tests_failed++;
      $display("FAIL basic_timing: got latency=%0d busy_cycles=%0d, want 33/33", lat, bc);
    end
    tests_run++;
    if (q !== 32'd14 || r !== 32'd2 || dz !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_100_7: got q=%h r=%h dz=%b busy=%b, want q=e r=2 dz=0 busy=0",
               q, r, dz, busy);
    end
    exp_q = 32'd14;
    exp_r = 32'd2;
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0 || quotient !== exp_q || remainder !== exp_r) begin
      tests_failed++;
      $display("FAIL done_single_cycle: got done=%b q=%h r=%h, want done=0 q=%h r=%h",
               done, quotient, remainder, exp_q, exp_r);
    end
  endtask

  task automatic test_signs;
    logic [31:0] q, r;
    logic dz;
    int lat, bc;
    run_div(32'hFFFF_FF9C, 32'd7, q, r, dz, lat, bc);
    tests_run++;
    if (q !== 32'hFFFF_FFF2 || r !== 32'hFFFF_FFFE || lat !== 33) begin
      tests_failed++;
      $display("FAIL neg_dividend: got q=%h r=%h lat=%0d, want q=fffffff2 r=fffffffe lat=33",
               q, r, lat);
    end
    run_div(32'd100, 32'hFFFF_FFF9, q, r, dz, lat, bc);
    tests_run++;
    if (q !== 32'hFFFF_FFF2 || r !== 32'd2 || lat !== 33) begin
      tests_failed++;
      $display("FAIL neg_divisor: got q=%h r=%h lat=%0d, want q=fffffff2 r=2 lat=33", q, r, lat);
    end
    exp_q = 32'hFFFF_FFF2;
    exp_r = 32'd2;
  endtask

  task automatic test_div_zero;
    logic [31:0] q, r;
    logic dz;
    int lat, bc;
    run_div(32'd7, 32'd0, q, r, dz, lat, bc);
    tests_run++;
    if (lat !== 0 || dz !== 1'b1 || busy !== 1'b0 || bc !== 0) begin
      tests_failed++;
      $display("FAIL div_zero_flag: got lat=%0d dz=%b busy=%b busy_cycles=%0d, want 0/1/0/0",
               lat, dz, busy, bc);
    end
    tests_run++;
    if (q !== exp_q || r !== exp_r) begin
      tests_failed++;
      $display("FAIL div_zero_hold: got q=%h r=%h, want q=%h r=%h", q, r, exp_q, exp_r);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0 || div_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_zero_pulse: got done=%b dz=%b one cycle later, want 0/0", done, div_zero);
    end
  endtask

  task automatic test_boundaries;
    logic [31:0] q, r;
    logic dz;
    int lat, bc;
    run_div(32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, lat, bc);
    tests_run++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || dz !== 1'b0 || lat !== 33) begin
      tests_failed++;
      $display("FAIL overflow: got q=%h r=%h dz=%b lat=%0d, want q=80000000 r=0 dz=0 lat=33",
               q, r, dz, lat);
    end
    run_div(32'd5, 32'd9, q, r, dz, lat, bc);
    tests_run++;
    if (q !== 32'd0 || r !== 32'd5) begin
      tests_failed++;
      $display("FAIL small_5_9: got q=%h r=%h, want q=0 r=5", q, r);
    end
    exp_q = 32'd0;
    exp_r = 32'd5;
  endtask

  task automatic test_ignore_start;
    int lat;
    dividend = 32'd1000;
    divisor  = 32'd10;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 10;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    tests_run++;
    if (lat !== 33 || quotient !== 32'd100 || remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL ignore_start: got lat=%0d q=%h r=%h, want lat=33 q=64 r=0",
               lat, quotient, remainder);
    end
    exp_q = 32'd100;
    exp_r = 32'd0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] q, r;
    logic dz;
    int lat, bc;
    run_div(32'd1000, 32'd10, q, r, dz, lat, bc);
    tests_run++;
    if (done !== 1'b1 || q !== 32'd100) begin
      tests_failed++;
      $display("FAIL b2b_first: got done=%b q=%h, want done=1 q=64", done, q);
    end
    // Still in the done cycle: the next request must be accepted right away.
    run_div(32'd50, 32'd5, q, r, dz, lat, bc);
    tests_run++;
    if (lat !== 33 || q !== 32'd10 || r !== 32'd0) begin
      tests_failed++;
      $display("FAIL b2b_second: got lat=%0d q=%h r=%h, want lat=33 q=a r=0", lat, q, r);
    end
    exp_q = 32'd10;
    exp_r = 32'd0;
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] q, r;
    logic dz;
    int lat, bc, done_cnt;
    dividend = 32'd1000;
    divisor  = 32'd10;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, div_zero, quotient, remainder} !== 67'd0) begin
      tests_failed++;
      $display("FAIL async_abort: got busy=%b done=%b q=%h r=%h, want all zero",
               busy, done, quotient, remainder);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    tests_run++;
    if (done_cnt !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got %0d cycles with done/busy after reset, want 0", done_cnt);
    end
    run_div(32'd9, 32'd3, q, r, dz, lat, bc);
    tests_run++;
    if (q !== 32'd3 || r !== 32'd0 || lat !== 33) begin
      tests_failed++;
      $display("FAIL after_abort: got q=%h r=%h lat=%0d, want q=3 r=0 lat=33", q, r, lat);
    end
    exp_q = 32'd3;
    exp_r = 32'd0;
  endtask

  task automatic test_random;
    logic [31:0] a, b, q, r, mq, mr;
    logic dz;
    int lat, bc;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'(-$signed({1'b0, 5'($urandom_range(1, 20))}));
        3:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if (b == 32'd0) begin
        mq = exp_q;
        mr = exp_r;
      end else begin
        ref_div(a, b, mq, mr);
      end
      run_div(a, b, q, r, dz, lat, bc);
      tests_run++;
      if (q !== mq || r !== mr || dz !== (b == 32'd0) || lat !== ((b == 32'd0) ? 0 : 33)) begin
        tests_failed++;
        $display("FAIL random_%0d: %h/%h got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b",
                 i, a, b, q, r, dz, lat, mq, mr, b == 32'd0);
      end
      exp_q = mq;
      exp_r = mr;
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_boundaries();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multicycle signed 32-bit divider for the MIPS-subset datapath. Executes DIV by consuming the A and B register outputs. Produces the quotient for LO and the remainder for HI through the LO/HI source muxes. Runs one restoring-division step per cycle under a start/done handshake driven by the control unit, and flags divide-by-zero so the control unit can branch to the exception sequence.

Parameters:
WIDTH, 32, operand and result width in bits; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request a division; sampled only in IDLE
dividend  input  WIDTH  two's-complement dividend (A register)
divisor  input  WIDTH  two's-complement divisor (B register)
busy  output  1  high while a division is in progress
done  output  1  one-cycle completion pulse
div_zero  output  1  one-cycle pulse, coincident with done, when divisor was 0
quotient  output  WIDTH  signed quotient (to LO source mux)
remainder  output  WIDTH  signed remainder (to HI source mux)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, div_zero=0, quotient=0, remainder=0, all internal registers 0.
- States: IDLE, RUN, FINISH.
- IDLE: done and div_zero are 1 only for the single cycle after completion, otherwise 0.
  - On an edge t0 with start=1 and divisor==0: stay in IDLE; set done=1 and div_zero=1 for exactly one cycle. quotient and remainder keep their old values. busy stays 0.
  - On an edge t0 with start=1 and divisor!=0:
    - latch |dividend| and |divisor| as unsigned WIDTH-bit magnitudes (|-2^31| = 0x80000000);
    - latch sign_q = dividend[MSB] XOR divisor[MSB] and sign_r = dividend[MSB];
    - clear the partial remainder (WIDTH+1 bits) and the iteration counter;
    - set busy=1 and go to RUN.
- RUN: each edge performs one restoring step:
  - shift {partial remainder, quotient magnitude} left by 1;
  - trial-subtract the divisor magnitude;
  - if the result is non-negative, keep it and set quotient bit 0 to 1; otherwise restore and set the bit to 0.
  - The counter increments each step. After WIDTH steps (edges t1..t32) go to FINISH.
- FINISH (edge t33):
  - quotient = sign_q ? -qmag : qmag (mod 2^WIDTH);
  - remainder = sign_r ? -rmag : rmag;
  - done=1 for the next cycle only; busy=0; go to IDLE.
- Latency: start sampled at t0, results valid and done=1 in the cycle after edge t33 (WIDTH+1 edges). Back-to-back start is accepted in that same done cycle.
- Semantics: quotient truncates toward zero; the remainder takes the sign of the dividend; dividend = quotient*divisor + remainder always holds.
- Overflow case -2^31 / -1: quotient=0x80000000, remainder=0. No flag is raised.
- start while busy=1 is ignored. The operand inputs may change freely during RUN because the latched copies are used.
- quotient and remainder hold their last completed values until the next non-zero-divisor completion; they never show intermediate values.
- Reset asserted mid-RUN aborts immediately to the reset values. No done pulse is produced.

Test Plan:
- dividend=100, divisor=7, start pulse at t0 -> busy=1 for 33 cycles, done=1 exactly one cycle after edge t33, quotient=14, remainder=2.
- dividend=-100 (0xFFFFFF9C), divisor=7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Repeat with 100/-7 -> quotient=-14, remainder=2.
- dividend=7, divisor=0 -> done=1 and div_zero=1 in the cycle after t0, busy never 1, quotient/remainder unchanged from the previous result.
- dividend=0x80000000, divisor=0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_zero=0. Also check 5/9 -> quotient=0, remainder=5.
- Start 1000/10; assert start again with 50/5 at cycle t10 -> second request ignored, result quotient=100, remainder=0. Then issue 50/5 in the done cycle -> accepted, quotient=10 after a further 34 cycles.
- Start 1000/10; drive reset=0 at cycle t15 asynchronously -> busy, done, quotient, remainder=0 immediately. After release, no done pulse; a new 9/3 gives quotient=3, remainder=0.
